// File: rtl/back_buffer_writer_if.sv
// Renderer pixel stream and frame-store write bus for the back-buffer writer.
// A pixel transfers on a rising edge where pix_valid && pix_ready; pix_data is held while pix_valid waits.
interface back_buffer_writer_if #(
    parameter int COLOR_W = 8,
    parameter int ADDR_W  = 20
);
    logic               pix_valid;
    logic [COLOR_W-1:0] pix_data;
    logic               pix_ready;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [COLOR_W-1:0] mem_data;
    logic               back_sel;
    logic               busy;
    logic               frame_done;
    logic               overrun;

    modport master (
        output pix_valid, pix_data,
        input  pix_ready, mem_we, mem_addr, mem_data, back_sel, busy, frame_done, overrun
    );

    modport slave (
        input  pix_valid, pix_data,
        output pix_ready, mem_we, mem_addr, mem_data, back_sel, busy, frame_done, overrun
    );
endinterface

// File: rtl/back_buffer_writer.sv
// Writes a raster pixel stream into the back half of a double-buffered frame store,
// restarting on every display swap and flagging swaps that arrive mid-frame.
module back_buffer_writer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int COLOR_W  = 8,
    parameter int ADDR_W   = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 buf_cntrl,
    back_buffer_writer_if.slave  bus,
    output logic [1:0]           dbg_state_o
);
    localparam int X_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int Y_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [ADDR_W-1:0] HV     = ADDR_W'(H_ACTIVE * V_ACTIVE);
    localparam logic [X_W-1:0]    X_LAST = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0]    Y_LAST = Y_W'(V_ACTIVE - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, DONE = 2'd2} state_t;

    state_t             state_q, state_d;
    logic               buf_q;
    logic               back_sel_q, back_sel_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               busy_q, busy_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [COLOR_W-1:0] mem_data_q, mem_data_d;
    logic               frame_done_q, frame_done_d;
    logic               overrun_q, overrun_d;
    logic               swap;
    logic               handshake;

    assign swap          = (buf_cntrl != buf_q);
    assign bus.pix_ready = (state_q == WRITE) && !swap;
    assign handshake     = bus.pix_valid && bus.pix_ready;

    always_comb begin
        state_d      = state_q;
        back_sel_d   = back_sel_q;
        x_d          = x_q;
        y_d          = y_q;
        addr_d       = addr_q;
        busy_d       = busy_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        frame_done_d = 1'b0;
        overrun_d    = 1'b0;
        // A swap in any state starts a fresh frame in the new back buffer.
        if (swap) begin
            overrun_d  = (state_q == WRITE);
            back_sel_d = ~buf_cntrl;
            x_d        = '0;
            y_d        = '0;
            addr_d     = buf_cntrl ? '0 : HV;
            busy_d     = 1'b1;
            state_d    = WRITE;
        end else if (handshake) begin
            mem_we_d   = 1'b1;
            mem_addr_d = addr_q;
            mem_data_d = bus.pix_data;
            addr_d     = addr_q + 1'b1;
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d          = '0;
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                    state_d      = DONE;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            buf_q        <= 1'b0;
            back_sel_q   <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            addr_q       <= '0;
            busy_q       <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_cntrl;
            back_sel_q   <= back_sel_d;
            x_q          <= x_d;
            y_q          <= y_d;
            addr_q       <= addr_d;
            busy_q       <= busy_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_data   = mem_data_q;
    assign bus.back_sel   = back_sel_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.overrun    = overrun_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_back_buffer_writer.sv
// Randomised bench for back_buffer_writer on a 4x2 frame, checked against a
// frame-level model (front buffer, pixel count) through an expected-write queue.
module tb_back_buffer_writer;
    localparam int H  = 4;
    localparam int V  = 2;
    localparam int HV = H * V;
    localparam int CW = 8;
    localparam int AW = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       buf_cntrl = 1'b0;
    logic [1:0] dbg_state;

    back_buffer_writer_if #(.COLOR_W(CW), .ADDR_W(AW)) bus ();

    back_buffer_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .COLOR_W(CW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .buf_cntrl  (buf_cntrl),
        .bus        (bus),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int wr_seen = 0;
    int fd_seen = 0;
    int ovr_seen = 0;

    logic [AW+CW:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: a swap starts a frame in the buffer that is not being displayed;
    // each accepted pixel n of that frame lands at base + n.
    logic m_prev, m_active, m_back, m_ovr;
    int   m_n, m_base;
    logic m_ready;
    assign m_ready = m_active && (buf_cntrl == m_prev);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev   <= 1'b0;
            m_active <= 1'b0;
            m_back   <= 1'b0;
            m_ovr    <= 1'b0;
            m_n      <= 0;
            m_base   <= 0;
            exp_q.delete();
        end else begin
            m_ovr <= 1'b0;
            if (buf_cntrl != m_prev) begin
                m_ovr    <= m_active;
                m_active <= 1'b1;
                m_back   <= ~buf_cntrl;
                m_base   <= buf_cntrl ? 0 : HV;
                m_n      <= 0;
            end else if (m_active && bus.pix_valid) begin
                exp_q.push_back({(m_n == HV - 1), 20'(m_base + m_n), bus.pix_data});
                m_n <= m_n + 1;
                if (m_n == HV - 1) m_active <= 1'b0;
            end
            m_prev <= buf_cntrl;
        end
    end

    always @(negedge clk) begin
        logic [AW+CW:0] e;
        chk("pix_ready", bus.pix_ready, m_ready);
        chk("busy", bus.busy, m_active);
        chk("back_sel", bus.back_sel, m_back);
        chk("overrun", bus.overrun, m_ovr);
        if (bus.overrun) ovr_seen++;
        if (bus.frame_done) fd_seen++;
        if (bus.mem_we) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("mem_addr", bus.mem_addr, e[AW+CW-1:CW]);
                chk("mem_data", bus.mem_data, e[CW-1:0]);
                chk("frame_done", bus.frame_done, e[AW+CW]);
            end
        end else begin
            chk("frame_done_without_write", bus.frame_done, 0);
        end
    end

    // mode 0: valid held high, 1: valid on alternate cycles, 2: random valid and data.
    task automatic run(input int cycles, input int mode, input int toggle_at);
        int k = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            if (c == toggle_at) buf_cntrl = ~buf_cntrl;
            case (mode)
                0:       bus.pix_valid = 1'b1;
                1:       bus.pix_valid = (c % 2 == 0);
                default: bus.pix_valid = 1'($urandom_range(1));
            endcase
            bus.pix_data = (mode == 2) ? 8'($urandom_range(255)) : 8'(8'h10 + k);
            @(negedge clk);
            if (bus.pix_valid && bus.pix_ready) k++;
        end
    endtask

    int wr0, fd0, ovr0;

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        repeat (2) @(negedge clk);
        chk("reset_mem_we", bus.mem_we, 0);
        chk("reset_mem_addr", bus.mem_addr, 0);
        chk("reset_mem_data", bus.mem_data, 0);
        chk("reset_state", dbg_state, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        wr0 = wr_seen; fd0 = fd_seen;
        run(12, 0, 0);
        chk("frame1_writes", wr_seen - wr0, 8);
        chk("frame1_done_count", fd_seen - fd0, 1);
        chk("frame1_ready_after", bus.pix_ready, 0);

        wr0 = wr_seen; fd0 = fd_seen;
        run(12, 0, 0);
        chk("frame2_back_sel", bus.back_sel, 1);
        chk("frame2_writes", wr_seen - wr0, 8);
        chk("frame2_done_count", fd_seen - fd0, 1);

        wr0 = wr_seen; fd0 = fd_seen;
        run(20, 1, 0);
        chk("gaps_writes", wr_seen - wr0, 8);
        chk("gaps_done_count", fd_seen - fd0, 1);

        wr0 = wr_seen; fd0 = fd_seen; ovr0 = ovr_seen;
        run(4, 0, 0);
        run(14, 0, 0);
        chk("overrun_count", ovr_seen - ovr0, 1);
        chk("overrun_writes", wr_seen - wr0, 3 + 8);
        chk("overrun_done_count", fd_seen - fd0, 1);

        run(4, 0, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_mem_we", bus.mem_we, 0);
        chk("midreset_busy", bus.busy, 0);
        chk("midreset_pix_ready", bus.pix_ready, 0);
        chk("midreset_state", dbg_state, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wr0 = wr_seen;
        run(8, 0, -1);
        chk("post_reset_no_writes", wr_seen - wr0, 0);
        chk("post_reset_busy", bus.busy, 0);

        for (int i = 0; i < 8; i++) run(10 + $urandom_range(10), 2, $urandom_range(14));
        run(30, 2, 0);

        bus.pix_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
